// File: rtl/button_press_unit_pkg.sv
// Shared definitions for the button press unit: debounce FSM encoding and
// synchronizer depth.
package button_press_unit_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_DB_RELEASE = 2'd3
  } btn_state_e;

endpackage

// File: rtl/button_press_unit_channel.sv
// One button channel: synchronizer, debounce FSM with stability counter,
// registered single-cycle press pulse and registered held level.
module button_channel
  import button_press_unit_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press_pulse,
  output logic held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync;
  btn_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   held_q, held_d;

  // Bit 0 is the first (metastability-exposed) stage; only the last is used.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
  assign sync   = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync) begin
          state_d = ST_DB_PRESS;
          cnt_d   = '0;
        end
      end
      ST_DB_PRESS: begin
        if (!sync) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PRESSED: begin
        if (!sync) begin
          state_d = ST_DB_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_DB_RELEASE: begin
        // A bounce back high returns to PRESSED silently: no second pulse.
        if (sync) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == ST_PRESSED) || (state_d == ST_DB_RELEASE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      held_q  <= held_d;
    end
  end

  assign press_pulse = pulse_q;
  assign held        = held_q;

endmodule

// File: rtl/button_press_unit.sv
// Two debounced button channels feeding the blinker shift inputs; coincident
// presses cancel each other so the shift outputs are never high together.
module button_press_unit
  import button_press_unit_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_left,
  input  logic btn_right,
  output logic shift_left,
  output logic shift_right,
  output logic left_held,
  output logic right_held
);

  logic left_pulse;
  logic right_pulse;

  button_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_left),
    .press_pulse (left_pulse),
    .held        (left_held)
  );

  button_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_right),
    .press_pulse (right_pulse),
    .held        (right_held)
  );

  // Ambiguous simultaneous presses are dropped rather than guessed at.
  assign shift_left  = left_pulse & ~right_pulse;
  assign shift_right = right_pulse & ~left_pulse;

endmodule

// File: tb/tb_button_press_unit.sv
// Directed bench for button_press_unit with DEBOUNCE_CYCLES=4; edge offsets
// below are counted from the first edge that samples the new button level.
module tb_button_press_unit;

  logic clk = 1'b0;
  logic rst;
  logic btn_left;
  logic btn_right;
  logic shift_left;
  logic shift_right;
  logic left_held;
  logic right_held;

  int checks = 0;
  int errors = 0;
  int pulses;
  int both_high;

  always #5 clk = ~clk;

  button_press_unit #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .shift_left  (shift_left),
    .shift_right (shift_right),
    .left_held   (left_held),
    .right_held  (right_held)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    btn_left = 1'b0;
    btn_right = 1'b0;
    repeat (3) step();
    chk("rst_shift_left", shift_left, 1'b0);
    chk("rst_shift_right", shift_right, 1'b0);
    chk("rst_left_held", left_held, 1'b0);
    chk("rst_right_held", right_held, 1'b0);
    rst = 1'b1;
    repeat (2) step();

    // Clean press: pulse only after edge E0+6, held rises at E0+6.
    btn_left = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("clean_pulse_e%0d", i), shift_left, (i == 6));
      chk($sformatf("clean_held_e%0d", i), left_held, (i >= 6));
      chk($sformatf("clean_right_e%0d", i), shift_right, 1'b0);
      $display("clean press edge E0+%0d shift_left=%b left_held=%b", i, shift_left, left_held);
    end

    // Release bounce: two low samples then high again keeps held, no pulse.
    btn_left = 1'b0;
    repeat (2) step();
    btn_left = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("relb_held_%0d", i), left_held, 1'b1);
      chk($sformatf("relb_pulse_%0d", i), shift_left, 1'b0);
    end
    $display("release bounce done left_held=%b", left_held);

    // Full release: held falls 6 edges after first sampled 0.
    btn_left = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("rel_held_e%0d", i), left_held, (i < 6));
      chk($sformatf("rel_pulse_e%0d", i), shift_left, 1'b0);
    end
    $display("full release done left_held=%b", left_held);

    // Press bounce 1,0,1 on the first three edges, then steady: pulse after B0+8.
    btn_left = 1'b1;
    step();
    chk("bnc_pulse_e0", shift_left, 1'b0);
    btn_left = 1'b0;
    step();
    chk("bnc_pulse_e1", shift_left, 1'b0);
    btn_left = 1'b1;
    step();
    chk("bnc_pulse_e2", shift_left, 1'b0);
    for (int i = 3; i < 12; i++) begin
      step();
      chk($sformatf("bnc_pulse_e%0d", i), shift_left, (i == 8));
      chk($sformatf("bnc_held_e%0d", i), left_held, (i >= 8));
    end
    $display("bounced press done left_held=%b", left_held);
    btn_left = 1'b0;
    repeat (10) step();
    chk("bnc_released", left_held, 1'b0);

    // Simultaneous press: both held rise together, no shift at all.
    btn_left = 1'b1;
    btn_right = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("sim_sl_e%0d", i), shift_left, 1'b0);
      chk($sformatf("sim_sr_e%0d", i), shift_right, 1'b0);
      chk($sformatf("sim_lh_e%0d", i), left_held, (i >= 6));
      chk($sformatf("sim_rh_e%0d", i), right_held, (i >= 6));
    end
    $display("simultaneous press done held=%b%b", left_held, right_held);
    btn_left = 1'b0;
    btn_right = 1'b0;
    repeat (10) step();

    // Right press while left is held pulses normally.
    btn_left = 1'b1;
    repeat (9) step();
    chk("hold_left_held", left_held, 1'b1);
    btn_right = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("other_sr_e%0d", i), shift_right, (i == 6));
      chk($sformatf("other_sl_e%0d", i), shift_left, 1'b0);
      chk($sformatf("other_lh_e%0d", i), left_held, 1'b1);
    end
    $display("press while other held done right_held=%b", right_held);

    // Reset asserted between edges clears held immediately.
    rst = 1'b0;
    #2;
    chk("async_rst_lh", left_held, 1'b0);
    chk("async_rst_rh", right_held, 1'b0);
    $display("async reset mid-hold held=%b%b", left_held, right_held);
    btn_left = 1'b0;
    btn_right = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    repeat (3) step();

    // Reset mid-debounce, button still high at release: new press from release.
    btn_left = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("mdb_rst_sl", shift_left, 1'b0);
    chk("mdb_rst_lh", left_held, 1'b0);
    for (int i = 3; i < 10; i++) begin
      step();
      chk($sformatf("mdb_in_rst_sl_e%0d", i), shift_left, 1'b0);
      chk($sformatf("mdb_in_rst_lh_e%0d", i), left_held, 1'b0);
    end
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("mdb_sl_e%0d", i), shift_left, (i == 6));
      chk($sformatf("mdb_lh_e%0d", i), left_held, (i >= 6));
    end
    $display("reset mid-debounce done left_held=%b", left_held);
    btn_left = 1'b0;
    repeat (10) step();

    // Long hold: exactly one right pulse over 200 cycles.
    pulses = 0;
    both_high = 0;
    btn_right = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (shift_right) pulses++;
      if (shift_left && shift_right) both_high++;
    end
    chk_int("long_hold_pulses", pulses, 1);
    chk_int("long_hold_both_high", both_high, 0);
    chk("long_hold_rh", right_held, 1'b1);
    $display("long hold done pulses=%0d", pulses);
    btn_right = 1'b0;
    repeat (10) step();
    chk("final_rh", right_held, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_press_unit.md
BUTTON_PRESS_UNIT -- requirements
Module: button_press_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: rst asserted at 0, released at 1.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable sampled cycles needed to accept a level change; legal range 1..65535.
REQ-003 Port clk, input, 1 bit: sole clock, rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 Port btn_left, input, 1 bit: raw, asynchronous, bouncing left button, active-high.
REQ-006 Port btn_right, input, 1 bit: raw, asynchronous, bouncing right button, active-high.
REQ-007 Port shift_left, output, 1 bit: one-cycle pulse per accepted left press; drives the blinker shift_left input.
REQ-008 Port shift_right, output, 1 bit: one-cycle pulse per accepted right press; drives the blinker shift_right input.
REQ-009 Port left_held, output, 1 bit: debounced left level.
REQ-010 Port right_held, output, 1 bit: debounced right level.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer; only the second-stage value (sync) SHALL be used downstream.
REQ-012 Each channel SHALL run a 4-state FSM: IDLE, DB_PRESS, PRESSED, DB_RELEASE.
REQ-013 IDLE: sync=1 -> DB_PRESS, counter cleared to 0; sync=0 -> stay.
REQ-014 DB_PRESS: sync=0 -> IDLE, counter cleared; sync=1 and counter=DEBOUNCE_CYCLES-1 -> PRESSED; otherwise counter increments.
REQ-015 PRESSED: sync=0 -> DB_RELEASE, counter cleared; sync=1 -> stay.
REQ-016 DB_RELEASE: sync=1 -> PRESSED with no new pulse; sync=0 and counter=DEBOUNCE_CYCLES-1 -> IDLE; otherwise counter increments.
REQ-017 Counter width SHALL be $clog2(DEBOUNCE_CYCLES)+1 bits; it SHALL never wrap, because every path clears it before it exceeds DEBOUNCE_CYCLES-1.
REQ-018 The channel's raw press pulse SHALL be registered and high for exactly the one cycle following the DB_PRESS->PRESSED edge.
REQ-019 Latency: for a clean press, the pulse SHALL be high in the cycle after edge E0+DEBOUNCE_CYCLES+2, where E0 is the first edge that samples the button high.
REQ-020 held SHALL be registered and high exactly while the state is PRESSED or DB_RELEASE.
REQ-021 Arbitration: if both channels' raw press pulses coincide in the same cycle, shift_left and shift_right SHALL both stay 0; held outputs are unaffected.
REQ-022 A press on one channel while the other is held SHALL pulse normally.
REQ-023 At most one pulse per accepted press: holding a button indefinitely SHALL produce no repeat pulses.
REQ-024 shift_left and shift_right SHALL never be high together.

Reset
REQ-025 rst=0 SHALL immediately force all synchronizer flops, counters and outputs to 0 and both FSMs to IDLE, independent of clk.
REQ-026 Reset asserted mid-debounce or mid-hold SHALL discard progress; no pulse SHALL be emitted during reset or on its release edge.
REQ-027 A button held through reset release SHALL be treated as a new press, pulsing per REQ-019 with E0 as the first edge after release.

Structure
REQ-028 The FSM state encoding (IDLE/DB_PRESS/PRESSED/DB_RELEASE) and the synchronizer depth constant (2) SHALL live in the shared lab package.
REQ-029 One sub-module, button_channel (synchronizer, FSM, counter, pulse and held registers), SHALL be instantiated twice; arbitration SHALL live in the top level.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Clean press: btn_left 0->1 sampled first at edge 10, held -> shift_left high only in the cycle after edge 16; left_held rises at edge 16.
REQ-031 Bounce: btn_left toggles 1,0,1 on edges 10..12, then stays 1 -> no pulse before edge 18; single pulse after edge 18.
REQ-032 Release bounce: from held, btn_left 0 for 2 cycles, then 1 -> left_held stays 1, no second pulse; then 0 for 6+ cycles -> left_held falls 6 edges after first sampled 0.
REQ-033 Simultaneous: btn_left and btn_right rise on the same edge -> both held outputs rise together, and both shift outputs stay 0 throughout.
REQ-034 Reset mid-debounce: rst=0 at edge 13 of a press started at edge 10, released at edge 20 with the button still high -> outputs 0 during reset; one pulse after edge 26.
REQ-035 Long hold: btn_right high for 200 cycles -> exactly one shift_right pulse.
